// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: one-hot FSM encoding,
// default width and MIN_INT / ALL_ONES helpers.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [4:0] S_IDLE    = 5'b00001;
  localparam logic [4:0] S_ITER    = 5'b00010;
  localparam logic [4:0] S_CORRECT = 5'b00100;
  localparam logic [4:0] S_SIGNFIX = 5'b01000;
  localparam logic [4:0] S_DONE    = 5'b10000;

  function automatic logic [63:0] min_int(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] all_ones(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/seq_divider_addsub.sv
// Add/subtract: y = a + (b ^ {sub}) + sub.
// Shared by iteration, correction, abs() and sign-fix negation.
module div_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/seq_divider.sv
// Radix-2 non-restoring divider, signed/unsigned, truncating.
// Start/done handshake; results held until the next completion.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_INT = WIDTH'(min_int(WIDTH));
  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [4:0]       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0] alu_a, alu_b, alu_y;
  logic [WIDTH:0] neg_b, neg_y;
  logic           alu_sub, neg_sub;
  logic           unused_neg;

  div_addsub #(.W(WIDTH + 1)) u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sub (alu_sub),
    .y   (alu_y)
  );

  div_addsub #(.W(WIDTH + 1)) u_neg (
    .a   ('0),
    .b   (neg_b),
    .sub (neg_sub),
    .y   (neg_y)
  );

  assign unused_neg = neg_y[WIDTH];

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;
    neg_b   = '0;
    neg_sub = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        alu_b   = {1'b0, dividend};
        alu_sub = is_signed & dividend[WIDTH-1];
        neg_b   = {1'b0, divisor};
        neg_sub = is_signed & divisor[WIDTH-1];
      end
      (state_q == S_ITER): begin
        alu_a   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        alu_b   = m_q;
        alu_sub = ~a_q[WIDTH];
      end
      (state_q == S_CORRECT): begin
        alu_a = a_q;
        alu_b = m_q;
      end
      (state_q == S_SIGNFIX): begin
        alu_b   = a_q;
        alu_sub = sr_q;
        neg_b   = {1'b0, q_q};
        neg_sub = sq_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          a_d     = '0;
          q_d     = alu_y[WIDTH-1:0];
          m_d     = {1'b0, neg_y[WIDTH-1:0]};
          sq_d    = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sr_d    = is_signed & dividend[WIDTH-1];
          dz_d    = 1'b0;
          state_d = S_ITER;
          // Special cases preload Q/A so SIGNFIX emits them unchanged
          if (divisor == '0) begin
            q_d     = ONES;
            a_d     = {1'b0, dividend};
            sq_d    = 1'b0;
            sr_d    = 1'b0;
            dz_d    = 1'b1;
            state_d = S_SIGNFIX;
          end else if (is_signed && dividend == MIN_INT
                       && divisor == ONES) begin
            q_d     = MIN_INT;
            sq_d    = 1'b0;
            sr_d    = 1'b0;
            state_d = S_SIGNFIX;
          end
        end
      end
      (state_q == S_ITER): begin
        a_d   = alu_y;
        q_d   = {q_q[WIDTH-2:0], ~alu_y[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_CORRECT;
      end
      (state_q == S_CORRECT): begin
        if (a_q[WIDTH]) a_d = alu_y;
        state_d = S_SIGNFIX;
      end
      (state_q == S_SIGNFIX): begin
        quot_d  = neg_y[WIDTH-1:0];
        rem_d   = alu_y[WIDTH-1:0];
        dbz_d   = dz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, handshake,
// mid-operation reset and random operands against a plain-arithmetic model.
module tb_seq_divider;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_vec;
  int n_bad;
  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_z;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic sgn, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] q,
                                output logic [31:0] r,
                                output logic z);
    int sa;
    int sb;
    sa = a;
    sb = b;
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] eq;
    logic [31:0] er;
    logic ez;
    int n;
    int lat;
    model(sgn, a, b, eq, er, ez);
    lat = (b == 0 || (sgn && a == 32'h8000_0000 && b == '1)) ? 1 : 34;
    @(negedge clk);
    start = 1'b1;
    is_signed = sgn;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    chk("busy_on", busy, 1);
    chk("prev_q_held", quotient, last_q);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, lat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
    chk("busy_off", busy, 0);
    @(posedge clk);
    #1;
    chk("done_fall", done, 0);
    chk("hold_r", remainder, er);
    last_q = eq;
    last_r = er;
    last_z = ez;
  endtask

  initial begin
    int dones;
    logic [31:0] ra;
    logic [31:0] rb;
    logic rs;
    n_vec = 0;
    n_bad = 0;
    last_q = 0;
    last_r = 0;
    last_z = 0;
    rst_b = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = 0;
    divisor = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_b = 1'b1;

    run_div(1, 100, 7);
    run_div(1, -100, 7);
    run_div(1, 100, -7);
    run_div(1, -100, -7);
    run_div(0, 32'hFFFF_FFFF, 2);
    run_div(1, 32'hFFFF_FFFF, 2);
    run_div(0, 5, 0);
    run_div(1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(0, 7, 100);
    run_div(0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(1, 32'h8000_0000, 3);

    // start re-pulsed mid-operation must be ignored
    @(negedge clk);
    start = 1'b1;
    is_signed = 1'b1;
    dividend = -100;
    divisor = 7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 9;
    divisor = 0;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk("repulse_q", quotient, 32'hFFFF_FFF2);
        chk("repulse_r", remainder, 32'hFFFF_FFFE);
        chk("repulse_dbz", div_by_zero, 0);
      end
    end
    chk("repulse_dones", dones, 1);
    last_q = 32'hFFFF_FFF2;

    // reset asserted mid-operation aborts with no done
    @(negedge clk);
    start = 1'b1;
    is_signed = 1'b1;
    dividend = 100;
    divisor = 7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_b = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("arst_no_done", dones, 0);
    last_q = 0;
    run_div(1, 100, 7);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = rb >> $urandom_range(1, 31);
        4: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_div(rs, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
